// File: rtl/tt_seg_pkg.sv
// Shared definitions for the seven-segment counter blocks: switch fields,
// mode encoding and the hex glyph table.
package tt_seg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int UI_MODE_LSB  = 0;
  localparam int UI_MODE_MSB  = 1;
  localparam int UI_SPEED_LSB = 2;
  localparam int UI_SPEED_MSB = 3;
  localparam int UI_LOAD_LSB  = 4;
  localparam int UI_LOAD_MSB  = 7;

  typedef struct packed {
    logic [UI_LOAD_MSB-UI_LOAD_LSB:0]   load;
    logic [UI_SPEED_MSB-UI_SPEED_LSB:0] speed;
    logic [UI_MODE_MSB-UI_MODE_LSB:0]   mode;
  } ui_sw_t;

  // Segment bit 0 is 'a', active high.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic mode_e decode_mode(input logic [1:0] bits);
    return mode_e'(bits);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg7_decode
  import tt_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/tt_um_seg_counter.sv
// Switch-controlled up/down/load counter, nibbles scanned onto one digit.
// Optional macro TT_SEG_SATURATE_EN: UP/DOWN saturate instead of wrapping.
module tt_um_seg_counter
  import tt_seg_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 22,
  parameter int SCAN_BIT   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam int NIBBLES = CNT_W / 4;
  localparam int SCAN_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NIBBLES - 1);

  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [7:0]            uo_q, uo_d;

  ui_sw_t                sw;
  mode_e                 mode;
  logic [PRESCALE_W-1:0] tick_mask;
  logic                  tick;
  logic                  scan_strobe;
  logic [CNT_W-1:0]      shifted;
  logic [3:0]            cur_nibble;
  logic [6:0]            seg;
  logic                  msd;

  assign sw   = ui_sw_t'(ui_in);
  assign mode = decode_mode(sw.mode);

  // Each speed step shortens the tick period by a factor of four.
  assign tick_mask   = {PRESCALE_W{1'b1}} >> {sw.speed, 1'b0};
  assign tick        = &(prescaler_q | ~tick_mask);
  assign scan_strobe = &prescaler_q[SCAN_BIT-1:0];

  assign prescaler_d = prescaler_q + PRESCALE_W'(1);

  always_comb begin
    counter_d = counter_q;
    case (mode)
      MODE_UP: begin
        if (tick) begin
`ifdef TT_SEG_SATURATE_EN
          if (counter_q != {CNT_W{1'b1}}) begin
            counter_d = counter_q + CNT_W'(1);
          end
`else
          counter_d = counter_q + CNT_W'(1);
`endif
        end
      end
      MODE_DOWN: begin
        if (tick) begin
`ifdef TT_SEG_SATURATE_EN
          if (counter_q != '0) begin
            counter_d = counter_q - CNT_W'(1);
          end
`else
          counter_d = counter_q - CNT_W'(1);
`endif
        end
      end
      MODE_LOAD: counter_d = CNT_W'(sw.load);
      default:   counter_d = counter_q;
    endcase
  end

  generate
    if (NIBBLES > 1) begin : g_scan
      always_comb begin
        scan_d = scan_q;
        if (scan_strobe) begin
          scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        end
      end
      assign msd = (scan_q == SCAN_LAST);
    end else begin : g_noscan
      assign scan_d = '0;
      assign msd    = 1'b0;
    end
  endgenerate

  // Display is built from the registered state, so it lags by one edge.
  assign shifted    = counter_q >> {scan_q, 2'b00};
  assign cur_nibble = shifted[3:0];

  seg7_decode u_seg7_decode (
    .nibble_i (cur_nibble),
    .seg_o    (seg)
  );

  assign uo_d = {msd, seg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      counter_q   <= '0;
      scan_q      <= '0;
      uo_q        <= 8'h3F;
    end else if (ena) begin
      prescaler_q <= prescaler_d;
      counter_q   <= counter_d;
      scan_q      <= scan_d;
      uo_q        <= uo_d;
    end
  end

  assign uo_out = uo_q;

endmodule
